// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard sequencer: FSM state encoding,
// forwarding select codes and the load result-select value.
package hazard_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      MD_BUSY  = 2'd1,
      MEM_WAIT = 2'd2
   } state_t;

   localparam logic [1:0] FWD_RF      = 2'b00;
   localparam logic [1:0] FWD_WB      = 2'b01;
   localparam logic [1:0] FWD_MEM     = 2'b10;
   localparam logic [1:0] RESULT_LOAD = 2'b01;

   // A later stage can supply a source operand when it writes a non-x0
   // register that matches the source.
   function automatic logic fwd_hit(input logic we, input logic [4:0] rd,
                                    input logic [4:0] rs);
      return we && (rd != 5'd0) && (rd == rs);
   endfunction

endpackage

// File: rtl/hazard_sequencer_if.sv
// Bundle of pipeline-side signals seen by the hazard sequencer.
// master = pipeline datapath side, slave = sequencer side.
interface hazard_sequencer_if #(
   parameter int CNT_W = 32
);
   logic [4:0]       Rs1D, Rs2D;
   logic [4:0]       Rs1E, Rs2E, RdE;
   logic [4:0]       RdM, RdW;
   logic             RegWriteM, RegWriteW;
   logic [1:0]       ResultSrcE;
   logic             PCSrcE;
   logic             MdStartE;
   logic             MemAccessM;
   logic             DMemReadyM;
   logic             StallF, StallD, StallE, StallM;
   logic             FlushD, FlushE, FlushM, FlushW;
   logic [1:0]       ForwardAE, ForwardBE;
   logic             MdBusy;
   logic [CNT_W-1:0] StallCount;

   modport master (
      output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, RegWriteM, RegWriteW,
             ResultSrcE, PCSrcE, MdStartE, MemAccessM, DMemReadyM,
      input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW,
             ForwardAE, ForwardBE, MdBusy, StallCount
   );

   modport slave (
      input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, RegWriteM, RegWriteW,
             ResultSrcE, PCSrcE, MdStartE, MemAccessM, DMemReadyM,
      output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW,
             ForwardAE, ForwardBE, MdBusy, StallCount
   );
endinterface

// File: rtl/forward_unit.sv
// Combinational operand-forwarding select for one EX source register.
// MEM is the younger producer, so it wins over WB.
module forward_unit
   import hazard_pkg::*;
(
   input  logic [4:0] rs,
   input  logic [4:0] rd_m,
   input  logic [4:0] rd_w,
   input  logic       reg_write_m,
   input  logic       reg_write_w,
   output logic [1:0] fwd
);

   // Pick the youngest stage holding the value, else the register file.
   always_comb begin
      fwd = FWD_RF;
      if (fwd_hit(reg_write_m, rd_m, rs)) begin
         fwd = FWD_MEM;
      end else if (fwd_hit(reg_write_w, rd_w, rs)) begin
         fwd = FWD_WB;
      end
   end

endmodule

// File: rtl/hazard_sequencer.sv
// Pipeline controller: stall/flush generation, forwarding selects, sequencing
// of the iterative MUL/DIV unit and data-memory wait states, and a
// stall-cycle performance counter.
module hazard_sequencer
   import hazard_pkg::*;
#(
   parameter int MD_LATENCY = 4,
   parameter int CNT_W      = 32
) (
   input  logic              clk,
   input  logic              reset_n,
   hazard_sequencer_if.slave hz
);

   localparam int            MD_W    = $clog2(MD_LATENCY);
   localparam logic [MD_W-1:0] MD_LOAD = MD_W'(MD_LATENCY - 2);

   state_t          state_reg, state_next;
   logic [MD_W-1:0] md_cnt_reg, md_cnt_next;
   logic            md_saved_reg, md_saved_next;
   logic [CNT_W-1:0] stall_count_reg;

   logic mem_req, mem_wait, md_active, load_use;
   logic stall_f, stall_d, stall_e, stall_m;
   logic flush_d, flush_e, flush_m, flush_w;
   logic md_busy;

   logic [4:0] rs_e    [2];
   logic [1:0] fwd_sel [2];

   assign rs_e[0] = hz.Rs1E;
   assign rs_e[1] = hz.Rs2E;

   for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
      forward_unit u_fwd (
         .rs          (rs_e[gi]),
         .rd_m        (hz.RdM),
         .rd_w        (hz.RdW),
         .reg_write_m (hz.RegWriteM),
         .reg_write_w (hz.RegWriteW),
         .fwd         (fwd_sel[gi])
      );
   end

   assign mem_req   = hz.MemAccessM && !hz.DMemReadyM;
   assign mem_wait  = (state_reg == MEM_WAIT) || ((state_reg == IDLE) && mem_req);
   assign md_active = (state_reg == MD_BUSY) || ((state_reg == IDLE) && hz.MdStartE);
   assign load_use  = (hz.ResultSrcE == RESULT_LOAD) && (hz.RdE != 5'd0) &&
                      ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));

   // FSM state, MD countdown and saved-MD flag.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg    <= IDLE;
         md_cnt_reg   <= '0;
         md_saved_reg <= 1'b0;
      end else begin
         state_reg    <= state_next;
         md_cnt_reg   <= md_cnt_next;
         md_saved_reg <= md_saved_next;
      end
   end

   // Next-state logic. The cycle that raises a memory wait during MD_BUSY
   // still counts as MD progress; the count is held only while in MEM_WAIT.
   always_comb begin
      state_next    = state_reg;
      md_cnt_next   = md_cnt_reg;
      md_saved_next = md_saved_reg;
      unique case (state_reg)
         IDLE: begin
            if (mem_req) begin
               state_next    = MEM_WAIT;
               md_saved_next = 1'b0;
            end else if (hz.MdStartE) begin
               state_next  = MD_BUSY;
               md_cnt_next = MD_LOAD;
            end
         end
         MD_BUSY: begin
            if (md_cnt_reg != '0) begin
               md_cnt_next = md_cnt_reg - MD_W'(1);
            end
            if (mem_req) begin
               state_next    = MEM_WAIT;
               md_saved_next = 1'b1;
            end else if (md_cnt_reg == '0) begin
               state_next = IDLE;
            end
         end
         MEM_WAIT: begin
            if (hz.DMemReadyM) begin
               md_saved_next = 1'b0;
               if (md_saved_reg) begin
                  state_next = MD_BUSY;
               end else if (hz.MdStartE) begin
                  state_next  = MD_BUSY;
                  md_cnt_next = MD_LOAD;
               end else begin
                  state_next = IDLE;
               end
            end
         end
         default: begin
            state_next    = IDLE;
            md_cnt_next   = '0;
            md_saved_next = 1'b0;
         end
      endcase
   end

   // Stall/flush priority: reset, memory wait, MD busy, taken branch, load-use.
   always_comb begin
      stall_f = 1'b0;
      stall_d = 1'b0;
      stall_e = 1'b0;
      stall_m = 1'b0;
      flush_d = 1'b0;
      flush_e = 1'b0;
      flush_m = 1'b0;
      flush_w = 1'b0;
      if (!reset_n) begin
         flush_d = 1'b1;
         flush_e = 1'b1;
         flush_m = 1'b1;
         flush_w = 1'b1;
      end else if (mem_wait) begin
         stall_f = 1'b1;
         stall_d = 1'b1;
         stall_e = 1'b1;
         stall_m = 1'b1;
         flush_w = 1'b1;
      end else if (md_active) begin
         stall_f = 1'b1;
         stall_d = 1'b1;
         stall_e = 1'b1;
         flush_m = 1'b1;
      end else if (hz.PCSrcE) begin
         flush_d = 1'b1;
         flush_e = 1'b1;
      end else if (load_use) begin
         stall_f = 1'b1;
         stall_d = 1'b1;
         flush_e = 1'b1;
      end
   end

   // MdBusy also covers the start cycle so it spans the full MD occupancy.
   assign md_busy = reset_n && (((state_reg == IDLE) && hz.MdStartE && !mem_req) ||
                                (state_reg == MD_BUSY) ||
                                ((state_reg == MEM_WAIT) && md_saved_reg));

   // Free-running count of fetch-stall cycles, wrapping naturally.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stall_count_reg <= '0;
      end else if (stall_f) begin
         stall_count_reg <= stall_count_reg + CNT_W'(1);
      end
   end

   assign hz.StallF     = stall_f;
   assign hz.StallD     = stall_d;
   assign hz.StallE     = stall_e;
   assign hz.StallM     = stall_m;
   assign hz.FlushD     = flush_d;
   assign hz.FlushE     = flush_e;
   assign hz.FlushM     = flush_m;
   assign hz.FlushW     = flush_w;
   assign hz.ForwardAE  = fwd_sel[0];
   assign hz.ForwardBE  = fwd_sel[1];
   assign hz.MdBusy     = md_busy;
   assign hz.StallCount = stall_count_reg;

endmodule

// File: tb/tb_hazard_sequencer.sv
// Scoreboard bench for hazard_sequencer: expected output vectors are queued
// as stimulus is driven and popped when the cycle's outputs are sampled.
module tb_hazard_sequencer;

   localparam int CNT_W = 32;

   // Output vector: {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushM,FlushW,MdBusy}
   localparam logic [8:0] E_IDLE  = 9'b0000_0000_0;
   localparam logic [8:0] E_MD    = 9'b1110_0010_1;
   localparam logic [8:0] E_MEM   = 9'b1111_0001_0;
   localparam logic [8:0] E_MEMMD = 9'b1111_0001_1;
   localparam logic [8:0] E_BR    = 9'b0000_1100_0;
   localparam logic [8:0] E_LU    = 9'b1100_0100_0;
   localparam logic [8:0] E_RST   = 9'b0000_1111_0;

   // Stimulus: {load_use_fields, MdStartE, MemAccessM, DMemReadyM, PCSrcE}
   localparam logic [4:0] S_IDLE = 5'b00010;
   localparam logic [4:0] S_PC   = 5'b00011;
   localparam logic [4:0] S_MD   = 5'b01010;
   localparam logic [4:0] S_LU   = 5'b10010;
   localparam logic [4:0] S_LUPC = 5'b10011;
   localparam logic [4:0] S_MW   = 5'b00100;
   localparam logic [4:0] S_MR   = 5'b00110;
   localparam logic [4:0] S_MWMP = 5'b01101;
   localparam logic [4:0] S_MRMP = 5'b01111;

   logic clk;
   logic reset_n;
   int   checks;
   int   errors;
   logic [CNT_W-1:0] exp_cnt;
   logic [8:0]  exp_q [$];
   logic [3:0]  fwd_q [$];

   hazard_sequencer_if #(.CNT_W(CNT_W)) hz ();

   hazard_sequencer #(.MD_LATENCY(4), .CNT_W(CNT_W)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .hz      (hz.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [8:0] obs();
      return {hz.StallF, hz.StallD, hz.StallE, hz.StallM,
              hz.FlushD, hz.FlushE, hz.FlushM, hz.FlushW, hz.MdBusy};
   endfunction

   task automatic drive_stim(input logic [4:0] s);
      hz.ResultSrcE = s[4] ? 2'b01 : 2'b00;
      hz.MdStartE   = s[3];
      hz.MemAccessM = s[2];
      hz.DMemReadyM = s[1];
      hz.PCSrcE     = s[0];
   endtask

   task automatic test_reset();
      logic [8:0] got, want;
      reset_n = 1'b0;
      hz.Rs1D = 5'd1; hz.Rs2D = 5'd2; hz.Rs1E = 5'd0; hz.Rs2E = 5'd0;
      hz.RdE = 5'd0; hz.RdM = 5'd0; hz.RdW = 5'd0;
      hz.RegWriteM = 1'b0; hz.RegWriteW = 1'b0;
      drive_stim(5'b01101);
      exp_q.push_back(E_RST);
      #3;
      got = obs(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin
         errors++; $display("FAIL reset_outputs got %b want %b", got, want);
      end else $display("reset_outputs %b ok", got);
      checks++;
      if (hz.StallCount !== '0) begin
         errors++; $display("FAIL reset_count got %0d want 0", hz.StallCount);
      end else $display("reset_count 0 ok");
      drive_stim(S_IDLE);
      repeat (2) @(posedge clk);
      @(negedge clk); #2 reset_n = 1'b1;
      exp_cnt = '0;
      @(posedge clk); #1;
      exp_q.push_back(E_IDLE);
      @(negedge clk);
      got = obs(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin
         errors++; $display("FAIL reset_release got %b want %b", got, want);
      end else $display("reset_release %b ok", got);
   endtask

   task automatic test_forwarding();
      logic [4:0] rs1 [6], rs2 [6], rdm [6], rdw [6];
      logic       rwm [6], rww [6];
      logic [3:0] ev  [6];
      logic [3:0] got, want;
      rs1 = '{5'd5, 5'd5, 5'd0, 5'd7, 5'd7,  5'd31};
      rs2 = '{5'd9, 5'd5, 5'd0, 5'd7, 5'd12, 5'd31};
      rdm = '{5'd5, 5'd0, 5'd0, 5'd7, 5'd12, 5'd31};
      rdw = '{5'd5, 5'd5, 5'd0, 5'd7, 5'd7,  5'd31};
      rwm = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
      rww = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      ev  = '{4'b10_00, 4'b01_01, 4'b00_00, 4'b01_01, 4'b00_10, 4'b00_00};
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         hz.Rs1E = rs1[i]; hz.Rs2E = rs2[i]; hz.RdM = rdm[i]; hz.RdW = rdw[i];
         hz.RegWriteM = rwm[i]; hz.RegWriteW = rww[i];
         fwd_q.push_back(ev[i]);
         @(negedge clk);
         got = {hz.ForwardAE, hz.ForwardBE}; want = fwd_q.pop_front(); checks++;
         if (got !== want) begin
            errors++; $display("FAIL forward row%0d got A/B %b want %b", i, got, want);
         end else $display("forward row%0d A/B %b ok", i, got);
      end
      hz.RegWriteM = 1'b0; hz.RegWriteW = 1'b0;
   endtask

   task automatic test_load_use();
      logic [4:0] rd [7], r1 [7], r2 [7], st [7];
      logic [8:0] ev [7];
      logic [8:0] got, want;
      rd = '{5'd3, 5'd3, 5'd3, 5'd3, 5'd0, 5'd6, 5'd6};
      r1 = '{5'd1, 5'd1, 5'd1, 5'd1, 5'd0, 5'd6, 5'd6};
      r2 = '{5'd3, 5'd3, 5'd3, 5'd3, 5'd0, 5'd2, 5'd2};
      st = '{S_LU, S_IDLE, S_LUPC, S_IDLE, S_LU, S_LU, S_IDLE};
      ev = '{E_LU, E_IDLE, E_BR, E_IDLE, E_IDLE, E_LU, E_IDLE};
      for (int c = 0; c < 7; c++) begin
         @(posedge clk); #1;
         hz.RdE = rd[c]; hz.Rs1D = r1[c]; hz.Rs2D = r2[c];
         drive_stim(st[c]);
         exp_q.push_back(ev[c]);
         @(negedge clk);
         got = obs(); want = exp_q.pop_front(); checks++;
         if (got !== want) begin
            errors++; $display("FAIL load_use c%0d got %b want %b", c, got, want);
         end else $display("load_use c%0d %b ok", c, got);
         exp_cnt += CNT_W'(want[8]);
      end
      checks++;
      if (hz.StallCount !== exp_cnt) begin
         errors++; $display("FAIL load_use_count got %0d want %0d", hz.StallCount, exp_cnt);
      end else $display("load_use_count %0d ok", exp_cnt);
   endtask

   task automatic test_mul_div();
      logic [4:0] st [6];
      logic [8:0] ev [6];
      logic [8:0] got, want;
      logic [CNT_W-1:0] cnt_start;
      int n_stall_e, n_busy;
      st = '{S_MD, S_IDLE, S_IDLE, S_IDLE, S_IDLE, S_IDLE};
      ev = '{E_MD, E_MD, E_MD, E_MD, E_IDLE, E_IDLE};
      n_stall_e = 0; n_busy = 0;
      cnt_start = exp_cnt;
      for (int c = 0; c < 6; c++) begin
         @(posedge clk); #1;
         drive_stim(st[c]);
         exp_q.push_back(ev[c]);
         @(negedge clk);
         got = obs(); want = exp_q.pop_front(); checks++;
         if (got !== want) begin
            errors++; $display("FAIL mul_div c%0d got %b want %b", c, got, want);
         end else $display("mul_div c%0d %b ok", c, got);
         n_stall_e += int'(got[6]); n_busy += int'(got[0]);
         exp_cnt += CNT_W'(want[8]);
      end
      checks++;
      if (n_stall_e != 4 || n_busy != 4) begin
         errors++; $display("FAIL mul_div_len got StallE %0d MdBusy %0d want 4 4", n_stall_e, n_busy);
      end else $display("mul_div_len 4 ok");
      checks++;
      if (hz.StallCount !== cnt_start + 32'd4) begin
         errors++; $display("FAIL mul_div_count got %0d want %0d", hz.StallCount, cnt_start + 32'd4);
      end else $display("mul_div_count %0d ok", hz.StallCount);
   endtask

   task automatic test_mem_during_md();
      logic [4:0] st [8];
      logic [8:0] ev [8];
      logic [8:0] got, want;
      int n_stall_m, n_stall_e;
      st = '{S_MD, S_IDLE, S_MW, S_MW, S_MW, S_MR, S_IDLE, S_IDLE};
      ev = '{E_MD, E_MD, E_MD, E_MEMMD, E_MEMMD, E_MEMMD, E_MD, E_IDLE};
      n_stall_m = 0; n_stall_e = 0;
      for (int c = 0; c < 8; c++) begin
         @(posedge clk); #1;
         drive_stim(st[c]);
         exp_q.push_back(ev[c]);
         @(negedge clk);
         got = obs(); want = exp_q.pop_front(); checks++;
         if (got !== want) begin
            errors++; $display("FAIL mem_in_md c%0d got %b want %b", c, got, want);
         end else $display("mem_in_md c%0d %b ok", c, got);
         n_stall_m += int'(got[5]); n_stall_e += int'(got[6]);
         exp_cnt += CNT_W'(want[8]);
      end
      checks++;
      if (n_stall_m != 3 || n_stall_e != 7) begin
         errors++; $display("FAIL mem_in_md_len got StallM %0d StallE %0d want 3 7", n_stall_m, n_stall_e);
      end else $display("mem_in_md_len 3 7 ok");
      checks++;
      if (hz.StallCount !== exp_cnt) begin
         errors++; $display("FAIL mem_in_md_count got %0d want %0d", hz.StallCount, exp_cnt);
      end else $display("mem_in_md_count %0d ok", exp_cnt);
   endtask

   task automatic test_deferred_branch();
      logic [4:0] st [6];
      logic [8:0] ev [6];
      logic [8:0] got, want;
      st = '{S_MD, S_PC, S_PC, S_PC, S_PC, S_IDLE};
      ev = '{E_MD, E_MD, E_MD, E_MD, E_BR, E_IDLE};
      for (int c = 0; c < 6; c++) begin
         @(posedge clk); #1;
         drive_stim(st[c]);
         exp_q.push_back(ev[c]);
         @(negedge clk);
         got = obs(); want = exp_q.pop_front(); checks++;
         if (got !== want) begin
            errors++; $display("FAIL defer_branch c%0d got %b want %b", c, got, want);
         end else $display("defer_branch c%0d %b ok", c, got);
         exp_cnt += CNT_W'(want[8]);
      end
   endtask

   task automatic test_mem_wait_idle();
      logic [4:0] st [7];
      logic [8:0] ev [7];
      logic [8:0] got, want;
      st = '{S_MWMP, S_MRMP, S_PC, S_PC, S_PC, S_PC, S_IDLE};
      ev = '{E_MEM, E_MEM, E_MD, E_MD, E_MD, E_BR, E_IDLE};
      for (int c = 0; c < 7; c++) begin
         @(posedge clk); #1;
         drive_stim(st[c]);
         exp_q.push_back(ev[c]);
         @(negedge clk);
         got = obs(); want = exp_q.pop_front(); checks++;
         if (got !== want) begin
            errors++; $display("FAIL mem_wait c%0d got %b want %b", c, got, want);
         end else $display("mem_wait c%0d %b ok", c, got);
         exp_cnt += CNT_W'(want[8]);
      end
      checks++;
      if (hz.StallCount !== exp_cnt) begin
         errors++; $display("FAIL mem_wait_count got %0d want %0d", hz.StallCount, exp_cnt);
      end else $display("mem_wait_count %0d ok", exp_cnt);
   endtask

   task automatic test_async_reset();
      logic [8:0] got, want;
      for (int c = 0; c < 2; c++) begin
         @(posedge clk); #1;
         drive_stim(c == 0 ? S_MD : S_IDLE);
         exp_q.push_back(E_MD);
         @(negedge clk);
         got = obs(); want = exp_q.pop_front(); checks++;
         if (got !== want) begin
            errors++; $display("FAIL async_pre c%0d got %b want %b", c, got, want);
         end else $display("async_pre c%0d %b ok", c, got);
         exp_cnt += CNT_W'(want[8]);
      end
      #2 reset_n = 1'b0;
      exp_cnt = '0;
      exp_q.push_back(E_RST);
      #1;
      got = obs(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin
         errors++; $display("FAIL async_in_reset got %b want %b", got, want);
      end else $display("async_in_reset %b ok", got);
      checks++;
      if (hz.StallCount !== exp_cnt) begin
         errors++; $display("FAIL async_count got %0d want 0", hz.StallCount);
      end else $display("async_count 0 ok");
      @(posedge clk);
      @(negedge clk); #2 reset_n = 1'b1;
      for (int c = 0; c < 2; c++) begin
         @(posedge clk); #1;
         drive_stim(S_IDLE);
         exp_q.push_back(E_IDLE);
         @(negedge clk);
         got = obs(); want = exp_q.pop_front(); checks++;
         if (got !== want) begin
            errors++; $display("FAIL async_post c%0d got %b want %b", c, got, want);
         end else $display("async_post c%0d %b ok", c, got);
      end
      checks++;
      if (hz.StallCount !== exp_cnt) begin
         errors++; $display("FAIL async_post_count got %0d want 0", hz.StallCount);
      end else $display("async_post_count 0 ok");
   endtask

   initial begin
      checks  = 0;
      errors  = 0;
      exp_cnt = '0;
      test_reset();
      test_forwarding();
      test_load_use();
      test_mul_div();
      test_mem_during_md();
      test_deferred_branch();
      test_mem_wait_idle();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
